// File: rtl/sr_reg_bank.sv
// Multi-channel bistable register bank: SR/JK/D/T selectable per cycle,
// with a configurable S=R=1 policy and SR-conflict monitoring.
module sr_reg_bank #(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0,
    parameter int unsigned      SR_CONFLICT = 0,
    parameter int unsigned      CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic [WIDTH-1:0] conflict_sticky,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam logic [1:0] MODE_SR = 2'b00;
    localparam logic [1:0] MODE_JK = 2'b01;
    localparam logic [1:0] MODE_D  = 2'b10;
    localparam logic [1:0] MODE_T  = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] conflict_c;
    logic [CNT_W-1:0] cnt_base_c;

    // Next-state for every channel plus monitor update; en=0 freezes everything.
    always_comb begin
        q_d        = q_q;
        sticky_d   = sticky_q;
        cnt_d      = cnt_q;
        conflict_c = '0;
        cnt_base_c = cnt_q;
        if (en) begin
            conflict_c = (mode == MODE_SR) ? (s & r) : '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                case (mode)
                    MODE_SR: begin
                        case ({s[i], r[i]})
                            2'b01:   q_d[i] = 1'b0;
                            2'b10:   q_d[i] = 1'b1;
                            2'b11: begin
                                case (SR_CONFLICT)
                                    0:       q_d[i] = q_q[i];
                                    1:       q_d[i] = 1'b0;
                                    2:       q_d[i] = 1'b1;
                                    default: q_d[i] = ~q_q[i];
                                endcase
                            end
                            default: q_d[i] = q_q[i];
                        endcase
                    end
                    MODE_JK: begin
                        case ({s[i], r[i]})
                            2'b01:   q_d[i] = 1'b0;
                            2'b10:   q_d[i] = 1'b1;
                            2'b11:   q_d[i] = ~q_q[i];
                            default: q_d[i] = q_q[i];
                        endcase
                    end
                    MODE_D:  q_d[i] = s[i];
                    MODE_T:  q_d[i] = s[i] ? ~q_q[i] : q_q[i];
                    default: q_d[i] = q_q[i];
                endcase
            end
            // A fresh conflict overrides a same-cycle clear.
            sticky_d   = (clr_flags ? '0 : sticky_q) | conflict_c;
            cnt_base_c = clr_flags ? '0 : cnt_q;
            if ((|conflict_c) && (cnt_base_c != CNT_MAX)) begin
                cnt_d = cnt_base_c + CNT_W'(1);
            end else begin
                cnt_d = cnt_base_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q      <= RESET_VAL;
            sticky_q <= '0;
            cnt_q    <= '0;
        end else begin
            q_q      <= q_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign q               = q_q;
    assign qn              = ~q_q;
    assign conflict_sticky = sticky_q;
    assign conflict_cnt    = cnt_q;

endmodule

// File: tb/tb_sr_reg_bank.sv
// Directed bench for sr_reg_bank: four instances (one per S=R=1 policy) share
// stimulus; a vector model feeds a scoreboard queue checked after each edge.
module tb_sr_reg_bank;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic [7:0] s, r;
    logic       clr_flags;

    logic [7:0] q_o   [4];
    logic [7:0] qn_o  [4];
    logic [7:0] st_o  [4];
    logic [7:0] cnt_o [4];
    logic [2:0] cnt_m;

    always #5 clk = ~clk;

    // Instance 0: policy toggle, RESET_VAL A5, 3-bit counter.
    sr_reg_bank #(.WIDTH(8), .RESET_VAL(8'hA5), .SR_CONFLICT(3), .CNT_W(3)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .s(s), .r(r),
        .clr_flags(clr_flags), .q(q_o[0]), .qn(qn_o[0]),
        .conflict_sticky(st_o[0]), .conflict_cnt(cnt_m));
    assign cnt_o[0] = 8'(cnt_m);

    sr_reg_bank #(.WIDTH(8), .RESET_VAL(8'h00), .SR_CONFLICT(0), .CNT_W(8)) u_p0 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .s(s), .r(r),
        .clr_flags(clr_flags), .q(q_o[1]), .qn(qn_o[1]),
        .conflict_sticky(st_o[1]), .conflict_cnt(cnt_o[1]));
    sr_reg_bank #(.WIDTH(8), .RESET_VAL(8'h00), .SR_CONFLICT(1), .CNT_W(8)) u_p1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .s(s), .r(r),
        .clr_flags(clr_flags), .q(q_o[2]), .qn(qn_o[2]),
        .conflict_sticky(st_o[2]), .conflict_cnt(cnt_o[2]));
    sr_reg_bank #(.WIDTH(8), .RESET_VAL(8'h00), .SR_CONFLICT(2), .CNT_W(8)) u_p2 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .s(s), .r(r),
        .clr_flags(clr_flags), .q(q_o[3]), .qn(qn_o[3]),
        .conflict_sticky(st_o[3]), .conflict_cnt(cnt_o[3]));

    typedef struct packed {
        logic [3:0][7:0] q;
        logic [3:0][7:0] st;
        logic [3:0][7:0] cnt;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    logic [7:0] mq   [4];
    logic [7:0] mst  [4];
    int         mcnt [4];
    int         cmax [4] = '{7, 255, 255, 255};
    int         pol  [4] = '{3, 0, 1, 2};
    logic [7:0] rval [4] = '{8'hA5, 8'h00, 8'h00, 8'h00};

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mq[i]   = rval[i];
            mst[i]  = 8'h00;
            mcnt[i] = 0;
        end
    endtask

    task automatic check_model(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_q%0d", tag, i),   q_o[i],   mq[i]);
            chk($sformatf("%s_qn%0d", tag, i),  qn_o[i],  ~mq[i]);
            chk($sformatf("%s_st%0d", tag, i),  st_o[i],  mst[i]);
            chk($sformatf("%s_cnt%0d", tag, i), cnt_o[i], 8'(mcnt[i]));
        end
    endtask

    // Drive one cycle at the falling edge, predict, then check after the rising edge.
    task automatic step(input string tag, input logic e, input logic [1:0] md,
                        input logic [7:0] ss, input logic [7:0] rr,
                        input logic c, input logic rel);
        exp_t       ex;
        logic [7:0] conf, both, base, pv;
        @(negedge clk);
        if (rel) rst_n = 1'b1;
        en = e; mode = md; s = ss; r = rr; clr_flags = c;
        if (e) begin
            conf = (md == 2'b00) ? (ss & rr) : 8'h00;
            both = ss & rr;
            for (int i = 0; i < 4; i++) begin
                case (md)
                    2'b00: begin
                        base = (mq[i] | (ss & ~rr)) & ~(~ss & rr);
                        case (pol[i])
                            0:       pv = mq[i];
                            1:       pv = 8'h00;
                            2:       pv = 8'hFF;
                            default: pv = ~mq[i];
                        endcase
                        mq[i] = (base & ~both) | (pv & both);
                    end
                    2'b01:   mq[i] = (mq[i] & ~ss & ~rr) | (ss & ~rr) | (both & ~mq[i]);
                    2'b10:   mq[i] = ss;
                    default: mq[i] = mq[i] ^ ss;
                endcase
                mst[i]  = (c ? 8'h00 : mst[i]) | conf;
                mcnt[i] = (c ? 0 : mcnt[i]) + ((conf != 8'h00) ? 1 : 0);
                if (mcnt[i] > cmax[i]) mcnt[i] = cmax[i];
            end
        end
        for (int i = 0; i < 4; i++) begin
            ex.q[i]   = mq[i];
            ex.st[i]  = mst[i];
            ex.cnt[i] = 8'(mcnt[i]);
        end
        sb.push_back(ex);
        @(posedge clk);
        #1;
        ex = sb.pop_front();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_q%0d", tag, i),   q_o[i],   ex.q[i]);
            chk($sformatf("%s_qn%0d", tag, i),  qn_o[i],  ~ex.q[i]);
            chk($sformatf("%s_st%0d", tag, i),  st_o[i],  ex.st[i]);
            chk($sformatf("%s_cnt%0d", tag, i), cnt_o[i], ex.cnt[i]);
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 2'b00; s = 8'h00; r = 8'h00; clr_flags = 1'b0;
        model_reset();
        #12;
        chk("rst_q",   q_o[0],   8'hA5);
        chk("rst_qn",  qn_o[0],  8'h5A);
        chk("rst_cnt", cnt_o[0], 8'h00);
        check_model("rst");

        // First edge after release loads 0F into every instance.
        step("load", 1'b1, 2'b10, 8'h0F, 8'h00, 1'b0, 1'b1);
        chk("load_q", q_o[0], 8'h0F);

        step("srconf", 1'b1, 2'b00, 8'hFF, 8'hFF, 1'b0, 1'b0);
        chk("pol0_q", q_o[1], 8'h0F);
        chk("pol1_q", q_o[2], 8'h00);
        chk("pol2_q", q_o[3], 8'hFF);
        chk("pol3_q", q_o[0], 8'hF0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("pol_st%0d", i),  st_o[i],  8'hFF);
            chk($sformatf("pol_cnt%0d", i), cnt_o[i], 8'h01);
        end

        // Mode sweep from zero, flags cleared on the same edge.
        step("zero", 1'b1, 2'b10, 8'h00, 8'h00, 1'b1, 1'b0);
        chk("zero_cnt", cnt_o[0], 8'h00);
        step("d",  1'b1, 2'b10, 8'h3C, 8'h00, 1'b0, 1'b0);
        chk("d_q", q_o[0], 8'h3C);
        step("t",  1'b1, 2'b11, 8'hFF, 8'h00, 1'b0, 1'b0);
        chk("t_q", q_o[0], 8'hC3);
        step("jk", 1'b1, 2'b01, 8'h01, 8'h80, 1'b0, 1'b0);
        chk("jk_q", q_o[0], 8'h43);
        step("jkt", 1'b1, 2'b01, 8'h02, 8'h02, 1'b0, 1'b0);
        chk("jkt_q", q_o[0], 8'h41);
        chk("jkt_cnt", cnt_o[0], 8'h00);

        for (int k = 0; k < 5; k++) step("hold", 1'b0, 2'b10, 8'hFF, 8'h00, 1'b0, 1'b0);
        chk("hold_q", q_o[0], 8'h41);
        step("en", 1'b1, 2'b10, 8'hFF, 8'h00, 1'b0, 1'b0);
        chk("en_q", q_o[0], 8'hFF);

        // 3-bit counter saturates at 7 while the wider ones keep counting.
        for (int k = 1; k <= 10; k++) begin
            step("sat", 1'b1, 2'b00, 8'hFF, 8'hFF, 1'b0, 1'b0);
            chk($sformatf("sat_cnt%0d", k), cnt_o[0], 8'((k < 7) ? k : 7));
        end
        chk("sat_wide", cnt_o[1], 8'd10);
        step("clr_off", 1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 1'b0);
        chk("clr_off_cnt", cnt_o[0], 8'd7);
        step("clr", 1'b1, 2'b00, 8'h00, 8'h00, 1'b1, 1'b0);
        chk("clr_cnt", cnt_o[0], 8'd0);
        chk("clr_st",  st_o[0],  8'h00);
        step("clrc", 1'b1, 2'b00, 8'h01, 8'h01, 1'b1, 1'b0);
        chk("clrc_cnt", cnt_o[0], 8'd1);
        chk("clrc_st",  st_o[0],  8'h01);

        // Reset in the middle of a JK toggle sequence.
        step("jkseq", 1'b1, 2'b01, 8'hFF, 8'hFF, 1'b0, 1'b0);
        step("jkseq", 1'b1, 2'b01, 8'hFF, 8'hFF, 1'b0, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_q",   q_o[0],   8'hA5);
        chk("mid_qn",  qn_o[0],  8'h5A);
        chk("mid_cnt", cnt_o[0], 8'h00);
        check_model("mid");
        @(posedge clk);
        #1;
        chk("mid_held", q_o[0], 8'hA5);
        step("rel", 1'b1, 2'b01, 8'hFF, 8'hFF, 1'b0, 1'b1);
        chk("rel_q", q_o[0], 8'h5A);

        chk("sb_empty", 8'(sb.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
